// File: rtl/operand_issue.sv
// Issue stage: resolves both source operands through mem/wb forwarding,
// interlocks on load-use hazards and stages the instruction for execute.

module operand_fwd (
  input  logic [4:0]  idx,
  input  logic        mem_we,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] rf,
  output logic [31:0] val
);
  // Youngest producer wins; x0 is hardwired and never forwarded.
  always_comb begin
    val = rf;
    if (idx == 5'd0)                                   val = 32'h0;
    else if (mem_we && mem_rd != 5'd0 && mem_rd == idx) val = mem_data;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == idx)    val = wb_data;
  end
endmodule

module operand_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_we,
  input  logic        id_is_load,
  output logic [4:0]  rf_r1_idx,
  output logic [4:0]  rf_r2_idx,
  input  logic [31:0] rf_r1,
  input  logic [31:0] rf_r2,
  input  logic        mem_we,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [4:0]  ex_rd,
  output logic        ex_we,
  output logic        ex_is_load,
  output logic [15:0] stall_cnt
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][4:0]  src_idx;
  logic [NUM_SRC-1:0][31:0] src_rf;
  logic [NUM_SRC-1:0][31:0] src_val;
  logic hazard, adv, take;

  assign src_idx   = {id_rs2, id_rs1};
  assign src_rf    = {rf_r2, rf_r1};
  assign rf_r1_idx = id_rs1;
  assign rf_r2_idx = id_rs2;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    operand_fwd u_fwd (
      .idx      (src_idx[gi]),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rf       (src_rf[gi]),
      .val      (src_val[gi])
    );
  end

  // Only a load still in execute can't forward yet; x0 writers never block.
  assign hazard   = ex_valid && ex_is_load && ex_we && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign adv      = !ex_valid || ex_ready;
  assign id_ready = flush || (adv && !hazard);
  assign take     = adv && id_valid && !hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_op_a    <= 32'h0;
      ex_op_b    <= 32'h0;
      ex_rd      <= 5'd0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
      stall_cnt  <= 16'h0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (take) begin
        ex_valid   <= 1'b1;
        ex_op_a    <= src_val[0];
        ex_op_b    <= src_val[1];
        ex_rd      <= id_rd;
        ex_we      <= id_we;
        ex_is_load <= id_is_load;
      end else if (adv) begin
        ex_valid <= 1'b0;
      end
      if (id_valid && hazard && !flush && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
